// File: rtl/mips_datapath.sv
// Single-cycle MIPS-32 datapath: PC, next-PC, 32x32 register file, extender, ALU, writeback mux.
// Optional macro DP_TRACE_EN adds a simulation-only write trace ($display).
`timescale 1ns/1ps
module mips_datapath #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IsBr,
  input  logic        Jump,
  input  logic        JType,
  input  logic        RegA3Sel,
  input  logic        SaveRA,
  input  logic [1:0]  DatatoReg,
  input  logic        RegWE,
  input  logic        ALUBSel,
  input  logic [1:0]  EXTCtrl,
  input  logic [7:0]  ALUCtrl,
  input  logic [31:0] Instr,
  input  logic [31:0] DMDataR,
  output logic [31:0] DMAdr,
  output logic [31:0] DMDataW,
  output logic [31:0] PC
);

  logic [4:0]  rs, rt, rd, shamt, a3;
  logic [15:0] imm;
  logic [25:0] index;
  logic [31:0] gpr [32];
  logic [31:0] rd1, rd2, ext, alu_b, alu_y, pc_q, pc4, wd, npc, br_off;
  logic        zero;
  logic        unused_bits;

  assign rs    = Instr[25:21];
  assign rt    = Instr[20:16];
  assign rd    = Instr[15:11];
  assign shamt = Instr[10:6];
  assign imm   = Instr[15:0];
  assign index = Instr[25:0];
  assign unused_bits = ^Instr[31:26];

  // Register 0 is hardwired; no bypass, so same-cycle reads see the old value.
  assign rd1 = (rs == 5'd0) ? 32'd0 : gpr[rs];
  assign rd2 = (rt == 5'd0) ? 32'd0 : gpr[rt];

  always_comb begin
    ext = {{16{imm[15]}}, imm};
    case (EXTCtrl)
      2'b00:   ext = {16'h0000, imm};
      2'b10:   ext = {imm, 16'h0000};
      default: ext = {{16{imm[15]}}, imm};
    endcase
  end

  assign alu_b = ALUBSel ? ext : rd2;

  always_comb begin
    alu_y = 32'd0;
    case (ALUCtrl)
      8'h00: alu_y = rd1 + alu_b;
      8'h01: alu_y = rd1 - alu_b;
      8'h02: alu_y = rd1 & alu_b;
      8'h03: alu_y = rd1 | alu_b;
      8'h04: alu_y = rd1 ^ alu_b;
      8'h05: alu_y = ~(rd1 | alu_b);
      8'h06: alu_y = {31'd0, $signed(rd1) < $signed(alu_b)};
      8'h07: alu_y = {31'd0, rd1 < alu_b};
      8'h08: alu_y = alu_b << shamt;
      8'h09: alu_y = alu_b >> shamt;
      8'h0A: alu_y = $unsigned($signed(alu_b) >>> shamt);
      8'h0B: alu_y = alu_b << rd1[4:0];
      8'h0C: alu_y = alu_b >> rd1[4:0];
      8'h0D: alu_y = $unsigned($signed(alu_b) >>> rd1[4:0]);
      default: alu_y = 32'd0;
    endcase
  end

  assign zero = (alu_y == 32'd0);
  assign pc4  = pc_q + 32'd4;

  assign a3 = SaveRA ? 5'd31 : (RegA3Sel ? rd : rt);

  always_comb begin
    wd = alu_y;
    if (SaveRA) wd = pc4;
    else begin
      case (DatatoReg)
        2'b00:   wd = alu_y;
        2'b01:   wd = DMDataR;
        2'b10:   wd = pc4;
        default: wd = ext;
      endcase
    end
  end

  assign br_off = {{14{imm[15]}}, imm, 2'b00};

  // Jump outranks branch regardless of IsBr.
  always_comb begin
    npc = pc4;
    if (Jump && !JType)   npc = {pc4[31:28], index, 2'b00};
    else if (Jump)        npc = rd1;
    else if (IsBr && zero) npc = pc4 + br_off;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= PC_RESET;
    else        pc_q <= npc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) gpr[i] <= 32'd0;
    end else if (RegWE && (a3 != 5'd0)) begin
      gpr[a3] <= wd;
    end
  end

  assign PC      = pc_q;
  assign DMAdr   = alu_y;
  assign DMDataW = rd2;

`ifdef DP_TRACE_EN
  always @(posedge clk) begin
    if (reset) begin
      if (RegWE && (a3 != 5'd0))
        $display("@%h: $%0d <= %h", pc_q, a3, wd);
      if ((DatatoReg == 2'b01) && !RegWE)
        $display("@%h: *%h <= %h", pc_q, alu_y, rd2);
    end
  end
`endif

endmodule

// File: tb/tb_mips_datapath.sv
// Self-checking bench for mips_datapath: directed scenarios plus randomized
// instructions checked against an architectural reference model.
`timescale 1ns/1ps
module tb_mips_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        IsBr, Jump, JType, RegA3Sel, SaveRA, RegWE, ALUBSel;
  logic [1:0]  DatatoReg, EXTCtrl;
  logic [7:0]  ALUCtrl;
  logic [31:0] Instr, DMDataR;
  logic [31:0] DMAdr, DMDataW, PC;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_gpr [32];
  logic [31:0] m_pc;

  mips_datapath dut (
    .clk(clk), .reset(reset), .IsBr(IsBr), .Jump(Jump), .JType(JType),
    .RegA3Sel(RegA3Sel), .SaveRA(SaveRA), .DatatoReg(DatatoReg), .RegWE(RegWE),
    .ALUBSel(ALUBSel), .EXTCtrl(EXTCtrl), .ALUCtrl(ALUCtrl), .Instr(Instr),
    .DMDataR(DMDataR), .DMAdr(DMAdr), .DMDataW(DMDataW), .PC(PC)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_rd(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : m_gpr[r];
  endfunction

  function automatic logic [31:0] m_ext(input logic [15:0] i, input logic [1:0] c);
    if (c == 2'b00) return {16'h0, i};
    if (c == 2'b10) return {i, 16'h0};
    return {{16{i[15]}}, i};
  endfunction

  function automatic logic [31:0] m_sra(input logic [31:0] v, input logic [4:0] n);
    return (v >> n) | (v[31] ? ~(32'hFFFF_FFFF >> n) : 32'd0);
  endfunction

  function automatic logic [31:0] m_alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] sh, input logic [7:0] op);
    case (op)
      8'h00: return a + b;
      8'h01: return a - b;
      8'h02: return a & b;
      8'h03: return a | b;
      8'h04: return a ^ b;
      8'h05: return ~(a | b);
      8'h06: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      8'h07: return (a < b) ? 32'd1 : 32'd0;
      8'h08: return b << sh;
      8'h09: return b >> sh;
      8'h0A: return m_sra(b, sh);
      8'h0B: return b << a[4:0];
      8'h0C: return b >> a[4:0];
      8'h0D: return m_sra(b, a[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_result();
    logic [31:0] e, b;
    e = m_ext(Instr[15:0], EXTCtrl);
    b = ALUBSel ? e : m_rd(Instr[20:16]);
    return m_alu(m_rd(Instr[25:21]), b, Instr[10:6], ALUCtrl);
  endfunction

  task automatic model_commit();
    logic [31:0] e, y, pc4, wd, npc;
    logic [4:0]  a3;
    e   = m_ext(Instr[15:0], EXTCtrl);
    y   = m_result();
    pc4 = m_pc + 32'd4;
    a3  = SaveRA ? 5'd31 : (RegA3Sel ? Instr[15:11] : Instr[20:16]);
    if (SaveRA) wd = pc4;
    else case (DatatoReg)
      2'b00: wd = y;
      2'b01: wd = DMDataR;
      2'b10: wd = pc4;
      default: wd = e;
    endcase
    if (Jump && !JType)       npc = {pc4[31:28], Instr[25:0], 2'b00};
    else if (Jump)            npc = m_rd(Instr[25:21]);
    else if (IsBr && y == 0)  npc = pc4 + ({{16{Instr[15]}}, Instr[15:0]} << 2);
    else                      npc = pc4;
    if (RegWE && a3 != 5'd0) m_gpr[a3] = wd;
    m_pc = npc;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_ctrl();
    IsBr = 0; Jump = 0; JType = 0; RegA3Sel = 0; SaveRA = 0; RegWE = 0;
    ALUBSel = 0; DatatoReg = 2'b00; EXTCtrl = 2'b00; ALUCtrl = 8'h00;
    Instr = 32'd0; DMDataR = 32'd0;
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ins(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [15:0] imm);
    return {6'd0, rs, rt, imm};
  endfunction

  function automatic logic [31:0] ins_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh);
    return {6'd0, rs, rt, rd, sh, 6'd0};
  endfunction

  task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
    clear_ctrl();
    Instr = ins(5'd0, r, 16'd0);
    #1;
    v = DMDataW;
    tick();
  endtask

  task automatic jump_to(input logic [31:0] target);
    clear_ctrl();
    Jump = 1; Instr = {6'd0, target[27:2]};
    #1;
    tick();
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    clear_ctrl();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (PC !== 32'h0000_3000) begin
      errors++; $display("FAIL reset_pc: got %h want %h", PC, 32'h0000_3000);
    end
    for (int r = 0; r < 32; r++) begin
      Instr = ins(5'd0, 5'(r), 16'd0);
      #1;
      checks++;
      if (DMDataW !== 32'd0) begin
        errors++; $display("FAIL reset_gpr%0d: got %h want 0", r, DMDataW);
      end
    end
    @(negedge clk);
    clear_ctrl();
    reset = 1'b1;
    tick();
    checks++;
    if (PC !== 32'h0000_3004) begin
      errors++; $display("FAIL reset_release_pc: got %h want %h", PC, 32'h0000_3004);
    end
  endtask

  task automatic test_imm();
    logic [31:0] v;
    clear_ctrl();
    Instr = ins(5'd0, 5'd1, 16'h1234); ALUBSel = 1; ALUCtrl = 8'h03; RegWE = 1;
    #1;
    checks++;
    if (DMDataW !== 32'd0) begin
      errors++; $display("FAIL no_bypass: got %h want 0", DMDataW);
    end
    tick();
    clear_ctrl();
    Instr = ins(5'd0, 5'd2, 16'h8000); EXTCtrl = 2'b10; DatatoReg = 2'b11; RegWE = 1;
    #1; tick();
    clear_ctrl();
    Instr = ins(5'd0, 5'd0, 16'hFFFF); ALUBSel = 1; ALUCtrl = 8'h03; RegWE = 1;
    #1;
    checks++;
    if (DMAdr !== 32'h0000_FFFF) begin
      errors++; $display("FAIL ori_zero_ext: got %h want %h", DMAdr, 32'h0000_FFFF);
    end
    tick();
    read_reg(5'd1, v);
    checks++;
    if (v !== 32'h0000_1234) begin errors++; $display("FAIL ori_r1: got %h want 00001234", v); end
    read_reg(5'd2, v);
    checks++;
    if (v !== 32'h8000_0000) begin errors++; $display("FAIL lui_r2: got %h want 80000000", v); end
    read_reg(5'd0, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL r0_write: got %h want 0", v); end
  endtask

  task automatic test_rtype();
    logic [31:0] v;
    logic [4:0]  rs_t [6] = '{5'd1, 5'd1, 5'd2, 5'd2, 5'd0, 5'd1};
    logic [4:0]  rt_t [6] = '{5'd2, 5'd2, 5'd1, 5'd1, 5'd2, 5'd2};
    logic [4:0]  rd_t [6] = '{5'd3, 5'd4, 5'd5, 5'd7, 5'd8, 5'd9};
    logic [7:0]  op_t [6] = '{8'h00, 8'h01, 8'h06, 8'h07, 8'h0A, 8'h20};
    logic [31:0] ex_t [6] = '{32'h8000_1234, 32'h8000_1234, 32'd1, 32'd0,
                              32'hF800_0000, 32'd0};
    for (int k = 0; k < 6; k++) begin
      clear_ctrl();
      Instr = ins_r(rs_t[k], rt_t[k], rd_t[k], 5'd4);
      RegA3Sel = 1; RegWE = 1; ALUCtrl = op_t[k];
      #1;
      checks++;
      if (DMAdr !== ex_t[k]) begin
        errors++; $display("FAIL rtype_op%0h: got %h want %h", op_t[k], DMAdr, ex_t[k]);
      end
      tick();
      read_reg(rd_t[k], v);
      checks++;
      if (v !== ex_t[k]) begin
        errors++; $display("FAIL rtype_wb_r%0d: got %h want %h", rd_t[k], v, ex_t[k]);
      end
    end
  endtask

  task automatic test_branch();
    jump_to(32'h0000_3010);
    checks++;
    if (PC !== 32'h0000_3010) begin errors++; $display("FAIL j_target: got %h want 00003010", PC); end
    clear_ctrl();
    IsBr = 1; ALUCtrl = 8'h01; Instr = ins(5'd1, 5'd1, 16'hFFFF);
    #1; tick();
    checks++;
    if (PC !== 32'h0000_3010) begin errors++; $display("FAIL beq_taken: got %h want 00003010", PC); end
    clear_ctrl();
    IsBr = 1; ALUCtrl = 8'h01; Instr = ins(5'd1, 5'd2, 16'hFFFF);
    #1; tick();
    checks++;
    if (PC !== 32'h0000_3014) begin errors++; $display("FAIL beq_not_taken: got %h want 00003014", PC); end
  endtask

  task automatic test_jump();
    logic [31:0] v;
    jump_to(32'h0000_3000);
    clear_ctrl();
    Jump = 1; SaveRA = 1; RegWE = 1; Instr = {6'd0, 26'h000_0C10};
    #1; tick();
    checks++;
    if (PC !== 32'h0000_3040) begin errors++; $display("FAIL jal_pc: got %h want 00003040", PC); end
    clear_ctrl();
    Jump = 1; JType = 1; Instr = ins(5'd31, 5'd0, 16'd0);
    #1; tick();
    checks++;
    if (PC !== 32'h0000_3004) begin errors++; $display("FAIL jr_pc: got %h want 00003004", PC); end
    read_reg(5'd31, v);
    checks++;
    if (v !== 32'h0000_3004) begin errors++; $display("FAIL jal_link: got %h want 00003004", v); end
  endtask

  task automatic test_mem();
    logic [31:0] v;
    clear_ctrl();
    Instr = ins(5'd1, 5'd3, 16'hFFFC); ALUBSel = 1; EXTCtrl = 2'b01; DatatoReg = 2'b01;
    #1;
    checks++;
    if (DMAdr !== 32'h0000_1230) begin errors++; $display("FAIL sw_adr: got %h want 00001230", DMAdr); end
    checks++;
    if (DMDataW !== 32'h8000_1234) begin errors++; $display("FAIL sw_data: got %h want 80001234", DMDataW); end
    tick();
    clear_ctrl();
    Instr = ins(5'd1, 5'd6, 16'h0008); ALUBSel = 1; EXTCtrl = 2'b01; DatatoReg = 2'b01;
    RegWE = 1; DMDataR = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (DMAdr !== 32'h0000_123C) begin errors++; $display("FAIL lw_adr: got %h want 0000123c", DMAdr); end
    tick();
    read_reg(5'd6, v);
    checks++;
    if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_wb: got %h want deadbeef", v); end
  endtask

  task automatic test_random();
    logic [31:0] v, e;
    for (int n = 0; n < 400; n++) begin
      Instr = $urandom; DMDataR = $urandom;
      IsBr = 1'($urandom_range(0, 1)); Jump = ($urandom_range(0, 5) == 0);
      JType = 1'($urandom_range(0, 1)); RegA3Sel = 1'($urandom_range(0, 1));
      SaveRA = ($urandom_range(0, 7) == 0); RegWE = ($urandom_range(0, 3) != 0);
      ALUBSel = 1'($urandom_range(0, 1)); DatatoReg = 2'($urandom_range(0, 3));
      EXTCtrl = 2'($urandom_range(0, 3));
      ALUCtrl = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 13));
      #1;
      e = m_result();
      checks++;
      if (DMAdr !== e) begin
        errors++; $display("FAIL rand_adr n=%0d op=%0h: got %h want %h", n, ALUCtrl, DMAdr, e);
      end
      checks++;
      if (DMDataW !== m_rd(Instr[20:16])) begin
        errors++; $display("FAIL rand_dataw n=%0d: got %h want %h", n, DMDataW, m_rd(Instr[20:16]));
      end
      tick();
      checks++;
      if (PC !== m_pc) begin
        errors++; $display("FAIL rand_pc n=%0d: got %h want %h", n, PC, m_pc);
      end
    end
    for (int r = 0; r < 32; r++) begin
      e = m_rd(5'(r));
      read_reg(5'(r), v);
      checks++;
      if (v !== e) begin
        errors++; $display("FAIL rand_gpr%0d: got %h want %h", r, v, e);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
    m_pc = 32'h0000_3000;
    clear_ctrl();
    test_reset();
    test_imm();
    test_rtype();
    test_branch();
    test_jump();
    test_mem();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_datapath.md
Name: mips_datapath

Overview:
- Single-cycle MIPS-32 datapath: PC register, next-PC logic, 32x32 register file, immediate extender, ALU and writeback mux.
- Driven by an external controller through decoded control lines; talks to external instruction and data memories (Instr in, DMDataR in; PC, DMAdr and DMDataW out).
- One instruction completes per clock.

Parameters:
- PC_RESET, 32'h0000_3000, PC value while reset is asserted and after it is released.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- IsBr  in  1  conditional branch instruction
- Jump  in  1  unconditional jump
- JType  in  1  jump kind: 0 = absolute j/jal target, 1 = register target (jr)
- RegA3Sel  in  1  write-register select: 0 = rt, 1 = rd
- SaveRA  in  1  link: forces write register to 31 and write data to PC+4
- DatatoReg  in  2  writeback source
- RegWE  in  1  register-file write enable
- ALUBSel  in  1  ALU B operand: 0 = rt value, 1 = extended immediate
- EXTCtrl  in  2  immediate extension mode
- ALUCtrl  in  8  ALU operation code
- Instr  in  32  current instruction word (fetched at PC)
- DMDataR  in  32  data-memory read data
- DMAdr  out  32  data-memory address; equals the ALU result
- DMDataW  out  32  data-memory write data; equals GPR[rt]
- PC  out  32  current program counter

Behaviour:
- Instruction fields: rs = Instr[25:21], rt = Instr[20:16], rd = Instr[15:11], shamt = Instr[10:6], imm = Instr[15:0], index = Instr[25:0].
- Reset (reset=0, asynchronous): PC = PC_RESET and all 32 GPRs = 0. Both hold until reset returns high; the first update is on the next rising clk after release.
- Register file:
  - Reads of rs and rt are combinational; register 0 always reads 0.
  - Write occurs on the rising edge when RegWE=1 and A3 != 0.
  - A3 = 31 if SaveRA=1, else rd if RegA3Sel=1, else rt.
  - No internal write-to-read bypass; a read in the same cycle as a write returns the old value.
- Extender, by EXTCtrl:
  - 00: zero-extend imm.
  - 01: sign-extend imm.
  - 10: {imm, 16'h0} (lui).
  - 11: sign-extend imm (same as 01).
- ALU inputs: A = GPR[rs]; B = ALUBSel ? EXT : GPR[rt]. Zero flag = (result == 0).
- ALUCtrl encoding:
  - 0x00 ADD (wrapping).
  - 0x01 SUB (wrapping).
  - 0x02 AND; 0x03 OR; 0x04 XOR; 0x05 NOR.
  - 0x06 SLT (signed, result 1/0); 0x07 SLTU (unsigned, result 1/0).
  - 0x08 SLL B by shamt; 0x09 SRL B by shamt; 0x0A SRA B by shamt.
  - 0x0B SLLV B by A[4:0]; 0x0C SRLV; 0x0D SRAV.
  - Any other code: result 0.
- There is no overflow trap.
- Writeback data:
  - If SaveRA=1: PC+4.
  - Otherwise by DatatoReg: 00 ALU result, 01 DMDataR, 10 PC+4, 11 EXT output.
- Next PC, in priority order:
  - Jump=1, JType=0: {PC4[31:28], index, 2'b00}, where PC4 = PC+4.
  - Jump=1, JType=1: GPR[rs].
  - IsBr=1 and Zero=1: PC4 + (sign-extended imm << 2).
  - Otherwise: PC4.
- All PC arithmetic is 32-bit wrapping; no delay slot.
- Controls are not checked for consistency: Jump overrides IsBr; SaveRA overrides RegA3Sel and DatatoReg.
- DMAdr, DMDataW and PC are purely combinational from the current state and inputs.

Optional Feature:
- Macro DP_TRACE_EN.
- When defined: on every rising edge that performs a register write, the block prints "@<PC hex>: $<A3 decimal> <= <data hex>" via $display. It also prints "@<PC hex>: *<DMAdr hex> <= <DMDataW hex>" when DatatoReg=01 and RegWE=0 (store-style access). The trace logic is simulation-only.
- When undefined: no trace code exists and behaviour is otherwise identical.

Test Plan:
- Hold reset=0, toggle clk -> PC=0x00003000, all GPRs read 0. Release reset -> PC=0x00003004 after the first rising edge with all controls 0.
- ori $1,$0,0x1234 (EXTCtrl=00, ALUBSel=1, ALUCtrl=0x03, RegWE=1, RegA3Sel=0, DatatoReg=00), then lui $2,0x8000 (EXTCtrl=10, DatatoReg=11) -> $1=0x00001234, $2=0x80000000. A write to $0 leaves $0 reading 0.
- addu $3,$1,$2 (RegA3Sel=1, ALUCtrl=0x00) -> $3=0x80001234. sub with $1-$2 -> 0x80001234 wrap. SLT $2<$1 -> 1; SLTU $2<$1 -> 0.
- beq with equal operands and imm=0xFFFF at PC=0x3010 -> next PC=0x3010. With unequal operands -> 0x3014.
- jal index=0x0000C10 at PC=0x3000 -> PC=0x00003040, $31=0x00003004. Then jr $31 (Jump=1, JType=1) -> PC=0x00003004.
- sw path: ALUBSel=1, EXTCtrl=01, imm=0xFFFC, rs=$1(0x1234) -> DMAdr=0x00001230, DMDataW=GPR[rt]. lw with DMDataR=0xDEADBEEF, DatatoReg=01 -> rt=0xDEADBEEF.
